// File: rtl/pixel_diffusion_decryptor_if.sv
// Stream bundle for the pixel diffusion decryptor: frame control, keystream,
// ciphertext and plaintext handshakes.
interface pixel_diffusion_decryptor_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [22:0] ks_data;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic        pt_last;

  modport master (
    output start, ks_data, ks_valid, ct_data, ct_valid, pt_ready,
    input  busy, done, ks_ready, ct_ready, pt_data, pt_valid, pt_last
  );

  modport slave (
    input  start, ks_data, ks_valid, ct_data, ct_valid, pt_ready,
    output busy, done, ks_ready, ct_ready, pt_data, pt_valid, pt_last
  );
endinterface

// File: rtl/pixel_diffusion_decryptor.sv
// Undoes c[i] = ((p[i] + k[i]) mod 256) ^ c[i-1] on a ciphertext/keystream pair,
// one pixel per cycle, with a single registered output slot.
module pixel_diffusion_decryptor #(
  parameter int unsigned NUM_PIXELS = 65536,
  parameter logic [7:0]  IV         = 8'hA5
) (
  input logic                        clk,
  input logic                        rst,
  pixel_diffusion_decryptor_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_PIXELS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [7:0]       prev_c;
  logic [CNT_W-1:0] count;
  logic [7:0]       pt_data_p1;
  logic             vld_p1;
  logic             last_p1;
  logic             busy_q;
  logic             done_q;
  logic             run;
  logic             out_free;
  logic             fire;

  function automatic logic [7:0] key_fold(input logic [22:0] ks);
    return ks[7:0] ^ ks[15:8] ^ {1'b0, ks[22:16]};
  endfunction

  // Modulo-256 subtraction: wrap is the intended inverse of the encryptor's add.
  function automatic logic [7:0] unchain(input logic [7:0] ct, input logic [7:0] prev,
                                         input logic [7:0] kb);
    logic [7:0] mixed;
    mixed = ct ^ prev;
    return mixed - kb;
  endfunction

  assign run      = (state == RUN);
  assign out_free = !vld_p1 || bus.pt_ready;
  assign fire     = run && bus.ct_valid && bus.ks_valid && out_free;

  // Both streams advance together; each ready only depends on the other side's valid.
  assign bus.ct_ready = run && bus.ks_valid && out_free;
  assign bus.ks_ready = run && bus.ct_valid && out_free;

  assign bus.pt_data  = pt_data_p1;
  assign bus.pt_valid = vld_p1;
  assign bus.pt_last  = last_p1;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_c     <= IV;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pt_data_p1 <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            prev_c <= IV;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (fire) begin
            prev_c <= bus.ct_data;
            count  <= count + CNT_W'(1);
            if (count == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p1 && bus.pt_ready) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase

      // p0 -> p1: recovered pixel enters the output slot
      if (fire) begin
        pt_data_p1 <= unchain(bus.ct_data, prev_c, key_fold(bus.ks_data));
        vld_p1     <= 1'b1;
        last_p1    <= (count == LAST_IDX);
      end else if (bus.pt_ready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_diffusion_decryptor.sv
// Bench for pixel_diffusion_decryptor: known vectors, hand sequences for stalls,
// backpressure and abort, and random frames checked against a forward-encryption model.
module tb_pixel_diffusion_decryptor;
  localparam int         NP  = 4;
  localparam logic [7:0] IVV = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  pixel_diffusion_decryptor_if bus ();

  pixel_diffusion_decryptor #(.NUM_PIXELS(NP), .IV(IVV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  ct;
    logic [22:0] ks;
    logic [7:0]  pt;
    logic        last;
  } vec_t;

  typedef struct {
    logic [7:0] pt;
    logic       last;
  } exp_t;

  vec_t       tbl[8];
  exp_t       expq[$];
  logic [7:0] mprev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] key_byte(input logic [22:0] k);
    return k[7:0] ^ k[15:8] ^ {1'b0, k[22:16]};
  endfunction

  // Forward cipher: encrypt a chosen plaintext so the DUT must give it back.
  task automatic encrypt_pixel(input logic [7:0] p, output logic [7:0] c, output logic [22:0] k);
    int s;
    k = 23'($urandom);
    s = (int'(p) + int'(key_byte(k))) % 256;
    c = 8'(s) ^ mprev;
    mprev = c;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    mprev = IVV;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     bus.busy,     1'b0);
    chk({tag, "_done"},     bus.done,     1'b0);
    chk({tag, "_ks_ready"}, bus.ks_ready, 1'b0);
    chk({tag, "_ct_ready"}, bus.ct_ready, 1'b0);
    chk({tag, "_pt_valid"}, bus.pt_valid, 1'b0);
    chk({tag, "_pt_data"},  bus.pt_data,  8'h00);
    chk({tag, "_pt_last"},  bus.pt_last,  1'b0);
  endtask

  task automatic run_frame(input bit full);
    int          fired    = 0;
    int          accepted = 0;
    int          cycles   = 0;
    logic [7:0]  p;
    logic [7:0]  c;
    logic [22:0] k;
    exp_t        e;
    expq.delete();
    pulse_start();
    #1 chk("run_busy", bus.busy, 1'b1);
    p = 8'($urandom);
    encrypt_pixel(p, c, k);
    while (accepted < NP && cycles < 200) begin
      if (fired < NP) begin
        bus.ct_data  = c;
        bus.ks_data  = k;
        bus.ct_valid = full || ($urandom_range(0, 3) != 0);
        bus.ks_valid = full || ($urandom_range(0, 3) != 0);
      end else begin
        bus.ct_valid = 1'b1;
        bus.ks_valid = 1'b1;
      end
      bus.pt_ready = full || ($urandom_range(0, 2) != 0);
      #1;
      if (fired == NP) chk("drain_ct_ready", bus.ct_ready, 1'b0);
      if (!bus.ks_valid) chk("stall_ct_ready", bus.ct_ready, 1'b0);
      if (!bus.ct_valid) chk("stall_ks_ready", bus.ks_ready, 1'b0);
      if (bus.pt_valid && !bus.pt_ready) chk("bp_ct_ready", bus.ct_ready, 1'b0);
      if (bus.pt_valid && bus.pt_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_pixel", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          chk("stream_pt_data", bus.pt_data, e.pt);
          chk("stream_pt_last", bus.pt_last, e.last);
        end
        accepted++;
      end
      if (bus.ct_valid && bus.ks_valid && bus.ct_ready && bus.ks_ready && fired < NP) begin
        e.pt   = p;
        e.last = (fired == NP - 1);
        expq.push_back(e);
        fired++;
        if (fired < NP) begin
          p = 8'($urandom);
          encrypt_pixel(p, c, k);
        end
      end
      @(negedge clk);
      cycles++;
    end
    chk("frame_pixels", accepted, NP);
    if (full) chk("full_rate_cycles", cycles, NP + 1);
    bus.ct_valid = 1'b0;
    bus.ks_valid = 1'b0;
    #1;
    chk("frame_done_pulse", bus.done, 1'b1);
    chk("frame_busy_off", bus.busy, 1'b0);
    @(negedge clk);
    #1 chk("frame_done_clear", bus.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ca;
    logic [7:0]  cb;
    logic [22:0] ka;
    logic [22:0] kb;

    tbl[0] = '{8'h37, 23'h000012, 8'h80, 1'b0};
    tbl[1] = '{8'h37, 23'h000000, 8'h00, 1'b0};
    tbl[2] = '{8'h32, 23'h000010, 8'hF5, 1'b0};
    tbl[3] = '{8'h00, 23'h000000, 8'h32, 1'b1};
    tbl[4] = '{8'h00, 23'h000000, 8'hA5, 1'b0};
    tbl[5] = '{8'hFF, 23'h7FFFFF, 8'h80, 1'b0};
    tbl[6] = '{8'h80, 23'h000001, 8'h7E, 1'b0};
    tbl[7] = '{8'h00, 23'h010101, 8'h7F, 1'b1};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.ct_data  = 8'h5A;
    bus.ks_data  = 23'h1234;
    bus.ct_valid = 1'b1;
    bus.ks_valid = 1'b1;
    bus.pt_ready = 1'b1;
    mprev        = IVV;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    rst          = 1'b0;
    bus.ct_valid = 1'b0;
    bus.ks_valid = 1'b0;
    @(negedge clk);
    #1 chk("idle_busy", bus.busy, 1'b0);

    // Known vectors over two frames of NP pixels.
    for (int i = 0; i < 8; i++) begin
      if (i % NP == 0) pulse_start();
      else @(negedge clk);
      bus.ct_data  = tbl[i].ct;
      bus.ks_data  = tbl[i].ks;
      bus.ct_valid = 1'b1;
      bus.ks_valid = 1'b1;
      bus.pt_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ct_ready", i), bus.ct_ready, 1'b1);
      chk($sformatf("vec%0d_ks_ready", i), bus.ks_ready, 1'b1);
      @(negedge clk);
      bus.ct_valid = 1'b0;
      bus.ks_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_pt_valid", i), bus.pt_valid, 1'b1);
      chk($sformatf("vec%0d_pt_data", i),  bus.pt_data,  tbl[i].pt);
      chk($sformatf("vec%0d_pt_last", i),  bus.pt_last,  tbl[i].last);
      if (i % NP == NP - 1) begin
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d_done", i), bus.done, 1'b1);
        chk($sformatf("vec%0d_busy", i), bus.busy, 1'b0);
        @(negedge clk);
        #1 chk($sformatf("vec%0d_done_clear", i), bus.done, 1'b0);
      end
    end

    run_frame(1'b1);

    // Stalls, backpressure with a stray start, then abort mid-frame.
    pulse_start();
    bus.ct_data  = 8'h11;
    bus.ks_data  = 23'h0;
    bus.ct_valid = 1'b1;
    bus.ks_valid = 1'b0;
    bus.pt_ready = 1'b1;
    #1 chk("stall_ks_ct_ready", bus.ct_ready, 1'b0);
    @(negedge clk);
    bus.ct_valid = 1'b0;
    bus.ks_valid = 1'b1;
    #1;
    chk("stall_ks_no_output", bus.pt_valid, 1'b0);
    chk("stall_ct_ks_ready", bus.ks_ready, 1'b0);
    @(negedge clk);
    #1 chk("stall_ct_no_output", bus.pt_valid, 1'b0);

    encrypt_pixel(8'h3C, ca, ka);
    bus.ct_data  = ca;
    bus.ks_data  = ka;
    bus.ct_valid = 1'b1;
    bus.ks_valid = 1'b1;
    bus.pt_ready = 1'b0;
    #1 chk("bp_first_ct_ready", bus.ct_ready, 1'b1);
    @(negedge clk);
    encrypt_pixel(8'hC3, cb, kb);
    bus.ct_data = cb;
    bus.ks_data = kb;
    bus.start   = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("bp%0d_ct_ready", j), bus.ct_ready, 1'b0);
      chk($sformatf("bp%0d_ks_ready", j), bus.ks_ready, 1'b0);
      chk($sformatf("bp%0d_pt_valid", j), bus.pt_valid, 1'b1);
      chk($sformatf("bp%0d_pt_data", j),  bus.pt_data,  8'h3C);
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.pt_ready = 1'b1;
    #1 chk("bp_release_ct_ready", bus.ct_ready, 1'b1);
    @(negedge clk);
    bus.ct_valid = 1'b0;
    bus.ks_valid = 1'b0;
    #1;
    chk("replace_pt_valid", bus.pt_valid, 1'b1);
    chk("replace_pt_data",  bus.pt_data,  8'hC3);
    #2 rst = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst          = 1'b0;
    bus.ct_valid = 1'b1;
    bus.ks_valid = 1'b1;
    #1 chk("no_start_ct_ready", bus.ct_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("no_start_pt_valid", bus.pt_valid, 1'b0);
    chk("no_start_busy", bus.busy, 1'b0);
    bus.ct_valid = 1'b0;
    bus.ks_valid = 1'b0;

    for (int f = 0; f < 4; f++) run_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
